mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single memory controller/RAM path between the instruction-fetch port (read-only)
//  and the data port (read/write). Round-robin arbitration; one transaction in flight.
//  Handshake is req/ack toward the requesters and valid/done toward the memory controller.
//  Sits between the CPU pipeline front/back ends and the memory controller.
// PARAMETERS
//  TIMEOUT_CYC   64   max cycles in WAIT before a timeout response (MEM_ARB_TIMEOUT_EN only)
//  DWIDTH, CPUAWIDTH  taken from package InstructionStruct, not overridden locally
// PORTS
//  clk        in   1          single clock, all logic on posedge
//  reset      in   1          synchronous, active-high
//  if_req     in   1          fetch request; held high until if_ack
//  if_addr    in   CPUAWIDTH  fetch byte address
//  if_ack     out  1          one-cycle pulse: if_rdata valid
//  if_rdata   out  DWIDTH     fetch read data
//  d_req      in   1          data request; held high until d_ack
//  d_rw       in   1          1=read, 0=write
//  d_addr     in   CPUAWIDTH  data byte address
//  d_wdata    in   DWIDTH     write data
//  d_ack      out  1          one-cycle pulse: write done / d_rdata valid
//  d_rdata    out  DWIDTH     data read data
//  mem_valid  out  1          one-cycle request strobe to controller
//  mem_rw     out  1          1=read, 0=write; stable from ISSUE until done
//  mem_addr   out  CPUAWIDTH  latched address; stable from ISSUE until done
//  mem_wdata  out  DWIDTH     latched write data; stable from ISSUE until done
//  mem_rdata  in   DWIDTH     read data, sampled on the cycle mem_done=1
//  mem_done   in   1          controller completion pulse
//  busy       out  1          high in any state other than IDLE
//  err        out  1          one-cycle pulse with the ack of a timed-out transaction
// BEHAVIOUR
//  - Reset (sync): state=IDLE, last_grant=DATA (so fetch wins the first tie).
//    All outputs 0: acks, mem_valid, busy, err, rdata/addr/wdata regs.
//  - FSM IDLE->ISSUE->WAIT->RESP->IDLE.
//  - IDLE: choose on any req; a single requester wins; both -> the one not in last_grant.
//    Latch addr/rw/wdata into mem_* regs (fetch forces rw=1). ->ISSUE.
//  - ISSUE: mem_valid=1 for exactly this cycle. ->WAIT.
//  - WAIT: on mem_done, capture mem_rdata into the winner's rdata reg. ->RESP.
//    mem_done sampled in ISSUE is ignored.
//  - RESP: winner's ack=1 for one cycle; last_grant<=winner. ->IDLE.
//    Loser's ack and rdata are unchanged.
//  - Write: rdata reg is not updated.
//  - Latency: req sampled in cycle t -> ack in cycle t+3+N, N = cycles WAIT holds before done (N>=0).
//    Back-to-back throughput is one access per 4+N cycles.
//  - Requesters must drop req the cycle after ack.
//    A req still high in the IDLE cycle after RESP is a new request.
//  - req dropped mid-transaction: access completes and ack still pulses.
//  - Addresses are passed unmodified; the controller does the word-address slice.
//  - Reset asserted in any state: IDLE on next edge, no ack issued, in-flight access abandoned.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//    - 8-bit counter clears on entry to WAIT.
//    - Reaching TIMEOUT_CYC with no mem_done -> RESP with rdata=0 and err=1 alongside the ack.
//  Undefined: no counter; WAIT waits forever; err tied 0.
// STRUCTURE
//  - Package InstructionStruct adds:
//    - typedef enum logic[1:0] {ARB_IDLE,ARB_ISSUE,ARB_WAIT,ARB_RESP} arb_state_t
//    - typedef enum logic {REQ_FETCH,REQ_DATA} arb_req_t
//    - localparam ARB_TIMEOUT_W=8
//  - Sub-module arb_rr2: 2-way round-robin picker.
//    - Inputs: req[1:0], last.
//    - Outputs: gnt, any. Combinational only.
//  - FSM and data latches stay in mem_arbiter.
// TESTING
//  1 Reset then both idle 10 cycles -> all outputs 0, busy=0.
//  2 if_req, if_addr=0x10; mem_done 2 cycles after mem_valid, mem_rdata=0xDEADBEEF
//    -> if_ack at t+5, if_rdata=0xDEADBEEF, mem_rw=1.
//  3 d_req write, d_addr=0x20, d_wdata=0x12345678 -> mem_rw=0 with addr/wdata on mem_*;
//    d_ack only; d_rdata unchanged.
//  4 if_req and d_req in the same cycle, both held -> grants in order FETCH,DATA,FETCH,DATA.
//  5 Reset pulsed in WAIT -> IDLE next cycle; no ack; new req then serviced normally.
//  6 With MEM_ARB_TIMEOUT_EN and mem_done never asserted -> ack+err at WAIT entry+64,
//    rdata=0. Without the macro: busy stays 1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
package InstructionStruct;
    localparam int DWIDTH        = 32;
    localparam int CPUAWIDTH     = 32;
    localparam int ARB_TIMEOUT_W = 8;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
    typedef enum logic {REQ_FETCH, REQ_DATA} arb_req_t;
endpackage

// File: rtl/mem_arbiter_rr2.sv
// Two-way round-robin picker: bit 0 is fetch, bit 1 is data.
module arb_rr2
    import InstructionStruct::*;
(
    input  logic [1:0] req,
    input  arb_req_t   last,
    output arb_req_t   gnt,
    output logic       any
);
    always_comb begin
        gnt = REQ_FETCH;
        any = |req;
        if (req[0] && req[1]) begin
            // On a tie the port that did not win last time goes first.
            gnt = (last == REQ_DATA) ? REQ_FETCH : REQ_DATA;
        end else if (req[1]) begin
            gnt = REQ_DATA;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory controller between fetch and data ports.
// Optional WAIT timeout with err pulse when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter
    import InstructionStruct::*;
`ifdef MEM_ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 64
)
`endif
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [CPUAWIDTH-1:0] if_addr,
    output logic                 if_ack,
    output logic [DWIDTH-1:0]    if_rdata,
    input  logic                 d_req,
    input  logic                 d_rw,
    input  logic [CPUAWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0]    d_wdata,
    output logic                 d_ack,
    output logic [DWIDTH-1:0]    d_rdata,
    output logic                 mem_valid,
    output logic                 mem_rw,
    output logic [CPUAWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0]    mem_wdata,
    input  logic [DWIDTH-1:0]    mem_rdata,
    input  logic                 mem_done,
    output logic                 busy,
    output logic                 err
);
    arb_state_t state, state_nxt;
    arb_req_t   winner, last_grant, gnt;
    logic       any_req;
    logic       tmo_hit;

    arb_rr2 u_rr (
        .req  ({d_req, if_req}),
        .last (last_grant),
        .gnt  (gnt),
        .any  (any_req)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    logic [ARB_TIMEOUT_W-1:0] tmo_cnt;
    logic                     tmo_flag;

    assign tmo_hit = (state == ARB_WAIT) && !mem_done &&
                     (tmo_cnt == ARB_TIMEOUT_W'(TIMEOUT_CYC - 1));

    // Counter starts at 0 on the first WAIT cycle; flag marks a timed-out RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if (state == ARB_ISSUE)
                tmo_cnt <= '0;
            else if (state == ARB_WAIT)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (state == ARB_WAIT)
                tmo_flag <= tmo_hit;
            else if (state == ARB_RESP)
                tmo_flag <= 1'b0;
        end
    end

    assign err = tmo_flag && (state == ARB_RESP);
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (any_req) state_nxt = ARB_ISSUE;
            ARB_ISSUE: state_nxt = ARB_WAIT;
            ARB_WAIT:  if (mem_done || tmo_hit) state_nxt = ARB_RESP;
            ARB_RESP:  state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= REQ_DATA;
            winner     <= REQ_FETCH;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && any_req) begin
                winner <= gnt;
                if (gnt == REQ_FETCH) begin
                    mem_rw    <= 1'b1;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                end else begin
                    mem_rw    <= d_rw;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end
            end
            // Only reads return data; a timed-out read returns zero.
            if (state == ARB_WAIT && mem_rw && (mem_done || tmo_hit)) begin
                if (winner == REQ_FETCH)
                    if_rdata <= mem_done ? mem_rdata : '0;
                else
                    d_rdata  <= mem_done ? mem_rdata : '0;
            end
            if (state == ARB_RESP)
                last_grant <= winner;
        end
    end

    assign mem_valid = (state == ARB_ISSUE);
    assign busy      = (state != ARB_IDLE);
    assign if_ack    = (state == ARB_RESP) && (winner == REQ_FETCH);
    assign d_ack     = (state == ARB_RESP) && (winner == REQ_DATA);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; timeout case follows MEM_ARB_TIMEOUT_EN.
module tb_mem_arbiter;
    import InstructionStruct::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 if_req = 1'b0;
    logic [CPUAWIDTH-1:0] if_addr = '0;
    logic                 if_ack;
    logic [DWIDTH-1:0]    if_rdata;
    logic                 d_req = 1'b0;
    logic                 d_rw = 1'b0;
    logic [CPUAWIDTH-1:0] d_addr = '0;
    logic [DWIDTH-1:0]    d_wdata = '0;
    logic                 d_ack;
    logic [DWIDTH-1:0]    d_rdata;
    logic                 mem_valid;
    logic                 mem_rw;
    logic [CPUAWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0]    mem_wdata;
    logic [DWIDTH-1:0]    mem_rdata = '0;
    logic                 mem_done = 1'b0;
    logic                 busy;
    logic                 err;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_rw      (d_rw),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_valid (mem_valid),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // flags = {if_ack, d_ack, mem_valid, busy, err}
    function automatic logic [31:0] flags();
        return {27'd0, if_ack, d_ack, mem_valid, busy, err};
    endfunction

    logic [31:0] exp_if, exp_d;
    logic [31:0] rd;

    initial begin
        // 1: reset and idle
        tick();
        tick();
        chk("rst_flags", flags(), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_rdata", if_rdata | d_rdata | mem_wdata, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_flags", flags(), 32'h0);
        end

        // 2: fetch read, WAIT holds 2 cycles before done
        if_req  = 1'b1;
        if_addr = 32'h10;
        tick();
        chk("f_issue_flags", flags(), 32'b00110);
        chk("f_issue_rw", {31'd0, mem_rw}, 32'd1);
        chk("f_issue_addr", mem_addr, 32'h10);
        tick();
        chk("f_wait1", flags(), 32'b00010);
        tick();
        chk("f_wait2", flags(), 32'b00010);
        tick();
        chk("f_wait3", flags(), 32'b00010);
        mem_done  = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        chk("f_resp_flags", flags(), 32'b10010);
        chk("f_rdata", if_rdata, 32'hDEADBEEF);
        mem_done = 1'b0;
        if_req   = 1'b0;
        tick();
        chk("f_idle", flags(), 32'h0);

        // 3: data write
        d_req   = 1'b1;
        d_rw    = 1'b0;
        d_addr  = 32'h20;
        d_wdata = 32'h12345678;
        tick();
        chk("w_issue_flags", flags(), 32'b00110);
        chk("w_rw", {31'd0, mem_rw}, 32'd0);
        chk("w_addr", mem_addr, 32'h20);
        chk("w_wdata", mem_wdata, 32'h12345678);
        tick();
        mem_done  = 1'b1;
        mem_rdata = 32'hAAAAAAAA;
        tick();
        chk("w_resp_flags", flags(), 32'b01010);
        chk("w_d_rdata", d_rdata, 32'h0);
        chk("w_if_rdata", if_rdata, 32'hDEADBEEF);
        mem_done = 1'b0;
        d_req    = 1'b0;
        tick();

        // 4: both requesting, held: FETCH, DATA, FETCH, DATA
        exp_if  = 32'hDEADBEEF;
        exp_d   = 32'h0;
        if_req  = 1'b1;
        if_addr = 32'h40;
        d_req   = 1'b1;
        d_rw    = 1'b1;
        d_addr  = 32'h80;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_addr", mem_addr, (k % 2 == 0) ? 32'h40 : 32'h80);
            chk("rr_rw", {31'd0, mem_rw}, 32'd1);
            tick();
            rd        = 32'hC000_0000 + k;
            mem_done  = 1'b1;
            mem_rdata = rd;
            tick();
            if (k % 2 == 0) exp_if = rd;
            else            exp_d  = rd;
            chk("rr_acks", flags(), (k % 2 == 0) ? 32'b10010 : 32'b01010);
            chk("rr_if_rdata", if_rdata, exp_if);
            chk("rr_d_rdata", d_rdata, exp_d);
            mem_done = 1'b0;
            if (k == 3) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
            tick();
        end
        chk("rr_end_idle", flags(), 32'h0);

        // 5: reset in WAIT abandons the access
        if_req  = 1'b1;
        if_addr = 32'h100;
        tick();
        tick();
        chk("r_in_wait", flags(), 32'b00010);
        reset     = 1'b1;
        mem_done  = 1'b1;
        mem_rdata = 32'h99;
        if_req    = 1'b0;
        tick();
        chk("r_flags", flags(), 32'h0);
        chk("r_rdata", if_rdata | d_rdata, 32'h0);
        reset    = 1'b0;
        mem_done = 1'b0;
        d_req    = 1'b1;
        d_rw     = 1'b1;
        d_addr   = 32'h200;
        tick();
        chk("r_new_issue", mem_addr, 32'h200);
        tick();
        mem_done  = 1'b1;
        mem_rdata = 32'h55;
        tick();
        chk("r_new_ack", flags(), 32'b01010);
        chk("r_new_rdata", d_rdata, 32'h55);
        mem_done = 1'b0;
        d_req    = 1'b0;
        tick();

        // 6: controller never answers
        d_req  = 1'b1;
        d_rw   = 1'b1;
        d_addr = 32'h300;
        tick();
        tick();
        d_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 1; i < 64; i++) begin
            tick();
            chk("t_waiting", flags(), 32'b00010);
        end
        tick();
        chk("t_ack_err", flags(), 32'b01011);
        chk("t_rdata", d_rdata, 32'h0);
        tick();
        chk("t_idle", flags(), 32'h0);
`else
        for (int i = 0; i < 100; i++) tick();
        chk("t_busy", flags(), 32'b00010);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
